or1k_wb_arbiter: RTL and testbench

- Parametrised Wishbone B3 multi-master arbiter for OR1K compute tiles.
- Merges NUM_MASTERS master ports onto one slave port, for example the instruction and data buses of one or more cores going to a shared memory or bus interface.
- Provides round-robin arbitration, whole-cycle bus locking for registered-feedback bursts, a per-transfer timeout watchdog that terminates hung transfers with err, and status outputs.

---
 rtl/or1k_wb_arbiter.sv | 117 +++++++++++
 tb/tb_or1k_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/or1k_wb_arbiter.sv
// or1k_wb_arbiter: round-robin Wishbone B3 arbiter merging NUM_MASTERS masters onto one slave, with cycle locking and a transfer watchdog
module or1k_wb_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int SEL_WIDTH     = DATA_WIDTH / 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]          m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]          m_bte_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic [NUM_MASTERS-1:0]            m_rty_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  output logic                              s_we_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic [2:0]                        s_cti_o,
  output logic [1:0]                        s_bte_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  input  logic                              s_err_i,
  input  logic                              s_rty_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              timeout_o
);
  localparam int RW = ADDR_WIDTH + DATA_WIDTH + SEL_WIDTH + 8;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TOERR = 2'd2;

  logic [1:0]                             r_state;
  logic [NUM_MASTERS-1:0]                 r_grant;
  logic [NUM_MASTERS-1:0]                 r_ptr;
  logic [15:0]                            r_wd;
  logic [NUM_MASTERS-1:0]                 w_hi, w_src, w_oh, w_nptr;
  logic [NUM_MASTERS-1:0][RW-1:0]         w_req;
  logic [RW-1:0][NUM_MASTERS-1:0]         w_col;
  logic [RW-1:0]                          w_sel;
  logic                                   w_act, w_gcyc, w_term, w_fire;

  // The pointer is kept one-hot; bits at or above it form the first-choice request set.
  assign w_hi  = m_cyc_i & ~(r_ptr - NUM_MASTERS'(1));
  assign w_src = (|w_hi) ? w_hi : m_cyc_i;
  assign w_oh  = w_src & (~w_src + NUM_MASTERS'(1));

  genvar k, b;
  for (k = 0; k < NUM_MASTERS; k++) begin : g_req
    assign w_req[k] = {m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH], m_dat_i[k*DATA_WIDTH +: DATA_WIDTH],
                       m_sel_i[k*SEL_WIDTH +: SEL_WIDTH], m_we_i[k], m_cyc_i[k], m_stb_i[k],
                       m_cti_i[k*3 +: 3], m_bte_i[k*2 +: 2]};
  end
  for (b = 0; b < RW; b++) begin : g_bit
    for (k = 0; k < NUM_MASTERS; k++) begin : g_and
      assign w_col[b][k] = r_grant[k] & w_req[k][b];
    end
    assign w_sel[b] = |w_col[b];
  end

  // Next pointer is the slot just above the owner, wrapping around.
  if (NUM_MASTERS == 1) begin : g_one
    assign w_nptr = 1'b1;
  end else begin : g_rot
    assign w_nptr = {r_grant[NUM_MASTERS-2:0], r_grant[NUM_MASTERS-1]};
  end

  assign w_act  = (r_state == GRANT);
  assign w_gcyc = |(m_cyc_i & r_grant);
  assign w_term = s_ack_i | s_err_i | s_rty_i;
  assign w_fire = (TIMEOUT_CYCLES > 0) && w_act && s_stb_o && !w_term && (r_wd == 16'(TIMEOUT_CYCLES - 1));

  assign {s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o} = w_act ? w_sel : '0;
  assign m_dat_o   = s_dat_i;
  assign m_ack_o   = (w_act && s_ack_i) ? r_grant : '0;
  assign m_err_o   = ((w_act && s_err_i) || r_state == TOERR) ? r_grant : '0;
  assign m_rty_o   = (w_act && s_rty_i) ? r_grant : '0;
  assign grant_o   = r_grant;
  assign timeout_o = (r_state == TOERR);

  // Arbitration FSM: grant from IDLE, hold for the whole cycle, one-cycle forced err on watchdog expiry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= NUM_MASTERS'(1);
      r_wd    <= '0;
    end else if (r_state == IDLE) begin
      r_wd <= '0;
      if (|m_cyc_i) begin
        r_state <= GRANT;
        r_grant <= w_oh;
      end
    end else if (r_state == GRANT && w_gcyc) begin
      r_state <= w_fire ? TOERR : GRANT;
      r_wd    <= (w_fire || !s_stb_o || w_term) ? '0 : r_wd + 16'd1;
    end else if (r_state == GRANT || !w_gcyc) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= w_nptr;
      r_wd    <= '0;
    end else begin
      r_state <= GRANT;
      r_wd    <= '0;
    end
  end
endmodule

// File: tb/tb_or1k_wb_arbiter.sv
// tb_or1k_wb_arbiter: directed per-cycle vector bench for or1k_wb_arbiter (3 masters with watchdog, 1 master without)
module tb_or1k_wb_arbiter;
  typedef struct {
    logic       rst;
    logic [2:0] cyc, stb;
    logic       ack, err, rty;
    logic [2:0] g;
    logic       sc, ss;
    logic [2:0] a, e, r;
    logic       to;
  } vec_t;

  vec_t vec[$];
  int   tests = 0;
  int   fails = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [95:0] m_adr, m_dat;
  logic [11:0] m_sel;
  logic [2:0]  m_we, m_cyc, m_stb;
  logic [8:0]  m_cti;
  logic [5:0]  m_bte;
  logic [31:0] m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [2:0]  m_ack_o, m_err_o, m_rty_o, grant_o, s_cti_o;
  logic [3:0]  s_sel_o;
  logic [1:0]  s_bte_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i, timeout_o;

  logic [31:0] b_adr, b_mdat_o, b_sadr, b_sdat;
  logic        b_cyc, b_stb, b_ack, b_err, b_rty, b_grant, b_to, b_swe, b_scyc, b_sstb;
  logic [3:0]  b_ssel;
  logic [2:0]  b_scti;
  logic [1:0]  b_sbte;

  always #5 clk = ~clk;

  or1k_wb_arbiter #(.NUM_MASTERS(3), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o),
    .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  or1k_wb_arbiter #(.NUM_MASTERS(1), .TIMEOUT_CYCLES(0)) u_one (
    .clk_i(clk), .rst_ni(rst_n),
    .m_adr_i(b_adr), .m_dat_i(32'h55), .m_sel_i(4'hF), .m_we_i(1'b0), .m_cyc_i(b_cyc), .m_stb_i(b_stb),
    .m_cti_i(3'b000), .m_bte_i(2'b00),
    .m_dat_o(b_mdat_o), .m_ack_o(b_ack), .m_err_o(b_err), .m_rty_o(b_rty),
    .s_adr_o(b_sadr), .s_dat_o(b_sdat), .s_sel_o(b_ssel), .s_we_o(b_swe), .s_cyc_o(b_scyc),
    .s_stb_o(b_sstb), .s_cti_o(b_scti), .s_bte_o(b_sbte),
    .s_dat_i(32'h0), .s_ack_i(1'b0), .s_err_i(1'b0), .s_rty_i(1'b0),
    .grant_o(b_grant), .timeout_o(b_to)
  );

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [2:0] cyc, input logic [2:0] stb, input logic ack,
                     input logic err, input logic rty, input logic [2:0] g, input logic sc, input logic ss,
                     input logic [2:0] a, input logic [2:0] e, input logic [2:0] r, input logic to);
    vec_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.ack = ack; v.err = err; v.rty = rty;
    v.g = g; v.sc = sc; v.ss = ss; v.a = a; v.e = e; v.r = r; v.to = to;
    vec.push_back(v);
  endtask

  task automatic quiet(input int n, input logic [2:0] cyc, input logic [2:0] stb, input logic [2:0] g,
                       input logic sc, input logic ss);
    for (int i = 0; i < n; i++) add(1'b0, cyc, stb, 1'b0, 1'b0, 1'b0, g, sc, ss, 3'b000, 3'b000, 3'b000, 1'b0);
  endtask

  function automatic logic [67:0] det(input logic [2:0] g);
    return g[0] ? {32'h1000, 1'b0, 3'b000, 32'hDEADBEEF} :
           g[1] ? {32'h2000, 1'b1, 3'b010, 32'hDEADBEEF} :
                  {32'h3000, 1'b0, 3'b111, 32'hDEADBEEF};
  endfunction

  initial begin
    m_adr = {32'h3000, 32'h2000, 32'h1000};
    m_dat = {32'hA2, 32'hA1, 32'hA0};
    m_sel = 12'hFFF;
    m_we  = 3'b010;
    m_cti = {3'b111, 3'b010, 3'b000};
    m_bte = {2'b01, 2'b00, 2'b00};
    m_cyc = 3'b111; m_stb = 3'b111;
    s_dat_i = 32'hDEADBEEF; s_ack_i = 1'b1; s_err_i = 1'b0; s_rty_i = 1'b0;
    b_adr = 32'h4000; b_cyc = 1'b1; b_stb = 1'b1;
    #3;
    chk("reset_slave", 128'({s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o}), 128'(0));
    chk("reset_master", 128'({grant_o, m_ack_o, m_err_o, m_rty_o, timeout_o}), 128'(0));
    chk("reset_one", 128'({b_grant, b_scyc, b_sstb, b_to, b_err}), 128'(0));
    s_ack_i = 1'b0; b_cyc = 1'b0; b_stb = 1'b0;

    // single master read with a retry then an ack
    quiet(1, 3'b001, 3'b001, 3'b000, 0, 0);
    quiet(1, 3'b001, 3'b001, 3'b001, 1, 1);
    add(0, 3'b001, 3'b001, 0, 0, 1, 3'b001, 1, 1, 3'b000, 3'b000, 3'b001, 0);
    quiet(1, 3'b001, 3'b001, 3'b001, 1, 1);
    add(0, 3'b001, 3'b001, 1, 0, 0, 3'b001, 1, 1, 3'b001, 3'b000, 3'b000, 0);
    quiet(1, 3'b000, 3'b000, 3'b001, 0, 0);
    quiet(1, 3'b000, 3'b000, 3'b000, 0, 0);
    add(1, 3'b000, 3'b000, 0, 0, 0, 3'b000, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    // round robin 0,1,2,0 with a turnaround cycle between owners
    quiet(1, 3'b111, 3'b111, 3'b000, 0, 0);
    add(0, 3'b111, 3'b111, 1, 0, 0, 3'b001, 1, 1, 3'b001, 3'b000, 3'b000, 0);
    quiet(1, 3'b110, 3'b110, 3'b001, 0, 0);
    quiet(1, 3'b110, 3'b110, 3'b000, 0, 0);
    add(0, 3'b110, 3'b110, 1, 0, 0, 3'b010, 1, 1, 3'b010, 3'b000, 3'b000, 0);
    quiet(1, 3'b101, 3'b101, 3'b010, 0, 0);
    quiet(1, 3'b101, 3'b101, 3'b000, 0, 0);
    add(0, 3'b101, 3'b101, 1, 0, 0, 3'b100, 1, 1, 3'b100, 3'b000, 3'b000, 0);
    quiet(1, 3'b001, 3'b001, 3'b100, 0, 0);
    quiet(1, 3'b001, 3'b001, 3'b000, 0, 0);
    add(0, 3'b001, 3'b001, 1, 0, 0, 3'b001, 1, 1, 3'b001, 3'b000, 3'b000, 0);
    quiet(1, 3'b000, 3'b000, 3'b001, 0, 0);
    quiet(1, 3'b000, 3'b000, 3'b000, 0, 0);
    // master 1 burst with an stb gap while master 0 keeps requesting
    quiet(1, 3'b011, 3'b011, 3'b000, 0, 0);
    for (int i = 0; i < 2; i++) add(0, 3'b011, 3'b011, 1, 0, 0, 3'b010, 1, 1, 3'b010, 3'b000, 3'b000, 0);
    quiet(1, 3'b011, 3'b001, 3'b010, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 3'b011, 3'b011, 1, 0, 0, 3'b010, 1, 1, 3'b010, 3'b000, 3'b000, 0);
    quiet(1, 3'b001, 3'b001, 3'b010, 0, 0);
    quiet(1, 3'b001, 3'b001, 3'b000, 0, 0);
    quiet(1, 3'b001, 3'b001, 3'b001, 1, 1);
    quiet(1, 3'b000, 3'b000, 3'b001, 0, 0);
    quiet(1, 3'b000, 3'b000, 3'b000, 0, 0);
    // master 2: slave err, then watchdog expiry, then ack on the last allowed cycle
    quiet(1, 3'b100, 3'b100, 3'b000, 0, 0);
    add(0, 3'b100, 3'b100, 0, 1, 0, 3'b100, 1, 1, 3'b000, 3'b100, 3'b000, 0);
    quiet(16, 3'b100, 3'b100, 3'b100, 1, 1);
    add(0, 3'b100, 3'b100, 1, 0, 0, 3'b100, 0, 0, 3'b000, 3'b100, 3'b000, 1);
    quiet(15, 3'b100, 3'b100, 3'b100, 1, 1);
    add(0, 3'b100, 3'b100, 1, 0, 0, 3'b100, 1, 1, 3'b100, 3'b000, 3'b000, 0);
    quiet(1, 3'b100, 3'b100, 3'b100, 1, 1);
    quiet(1, 3'b000, 3'b000, 3'b100, 0, 0);
    quiet(1, 3'b000, 3'b000, 3'b000, 0, 0);
    // master 0 drops cyc on the cycle the watchdog would expire
    quiet(1, 3'b001, 3'b001, 3'b000, 0, 0);
    quiet(15, 3'b001, 3'b001, 3'b001, 1, 1);
    quiet(1, 3'b000, 3'b001, 3'b001, 0, 1);
    quiet(1, 3'b000, 3'b000, 3'b000, 0, 0);

    for (int i = 0; i < vec.size(); i++) begin
      @(negedge clk);
      rst_n = !vec[i].rst; m_cyc = vec[i].cyc; m_stb = vec[i].stb;
      s_ack_i = vec[i].ack; s_err_i = vec[i].err; s_rty_i = vec[i].rty;
      #1;
      chk($sformatf("row%0d", i), 128'({grant_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, timeout_o}),
          128'({vec[i].g, vec[i].sc, vec[i].ss, vec[i].a, vec[i].e, vec[i].r, vec[i].to}));
      if (vec[i].g != 3'b000 && !vec[i].to)
        chk($sformatf("row%0d_data", i), 128'({s_adr_o, s_we_o, s_cti_o, m_dat_o}), 128'(det(vec[i].g)));
    end

    // asynchronous reset during beat 2 of a master 1 burst; pointer must restart at 0
    @(negedge clk); s_ack_i = 1'b0; m_cyc = 3'b010; m_stb = 3'b010;
    @(negedge clk); s_ack_i = 1'b1; #1;
    chk("burst_beat1", 128'({grant_o, m_ack_o}), 128'({3'b010, 3'b010}));
    @(negedge clk); s_ack_i = 1'b0; #1;
    chk("burst_beat2", 128'({grant_o, s_cyc_o}), 128'({3'b010, 1'b1}));
    #1 rst_n = 1'b0;
    #1 chk("async_reset", 128'({grant_o, s_cyc_o, s_stb_o, s_adr_o}), 128'(0));
    @(negedge clk); rst_n = 1'b1; m_cyc = 3'b011; m_stb = 3'b011; #1;
    chk("post_reset_idle", 128'({grant_o, s_cyc_o}), 128'(0));
    @(negedge clk); #1;
    chk("post_reset_ptr0", 128'(grant_o), 128'(3'b001));
    @(negedge clk); m_cyc = 3'b000; m_stb = 3'b000;

    // single master, watchdog disabled, silent slave
    @(negedge clk); b_cyc = 1'b1; b_stb = 1'b1; #1;
    chk("one_idle", 128'({b_grant, b_scyc}), 128'(0));
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      chk($sformatf("one_hold%0d", i), 128'({b_grant, b_scyc, b_sstb, b_err, b_to, b_ack, b_rty, b_sadr}),
          128'({7'b1110000, 32'h4000}));
    end
    @(negedge clk); b_cyc = 1'b0; b_stb = 1'b0; #1;
    chk("one_drop", 128'({b_grant, b_scyc}), 128'(2'b10));
    @(negedge clk); b_cyc = 1'b1; b_stb = 1'b1; #1;
    chk("one_turnaround", 128'({b_grant, b_scyc}), 128'(2'b00));
    @(negedge clk); #1;
    chk("one_regrant", 128'({b_grant, b_scyc}), 128'(2'b11));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
